// File: rtl/usr_reg_func_ctrl_pkg.sv
// Shared types and default codes for the JTAG user-register function-select controller.
package usr_reg_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam logic [7:0] DEF_CHAIN_CODE = 8'hFF;
    localparam logic [7:0] DEF_NOP_CODE   = 8'h00;

    // Counter must reach FW+1 so over-long scans stay distinguishable from exact ones.
    function automatic int cnt_width(input int fw);
        return $clog2(fw + 2);
    endfunction

endpackage

// File: rtl/usr_reg_func_ctrl_if.sv
// BSCAN-side and register-bank-side signals of the function-select controller.
interface usr_reg_func_ctrl_if #(
    parameter int NREG = 8,
    parameter int FW   = 8
);
    logic            SEL;
    logic            SHIFT;
    logic            UPDATE;
    logic            TDI;
    logic [NREG-1:0] LD_REQ;
    logic [NREG-1:0] FSEL;
    logic            DSY_CHAIN;
    logic            TDO;
    logic [NREG-1:0] LOAD;
    logic [FW-1:0]   ACTIVE_FUNC;
    logic            BAD_CODE;
    logic            BUSY;

    modport master (
        output SEL, SHIFT, UPDATE, TDI, LD_REQ,
        input  FSEL, DSY_CHAIN, TDO, LOAD, ACTIVE_FUNC, BAD_CODE, BUSY
    );

    modport slave (
        input  SEL, SHIFT, UPDATE, TDI, LD_REQ,
        output FSEL, DSY_CHAIN, TDO, LOAD, ACTIVE_FUNC, BAD_CODE, BUSY
    );
endinterface

// File: rtl/usr_reg_func_ctrl_arb.sv
// Round-robin arbiter with a registered one-hot grant; the search starts at the pointer,
// which moves just past each winner.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]  grant_reg, grant_next;
    logic [N-1:0]  cand;
    logic [PW-1:0] idx;
    logic          found;
    int            pos;

    assign cand  = req & ~mask;
    assign grant = grant_reg;

    always_comb begin
        grant_next = '0;
        ptr_next   = ptr_reg;
        found      = 1'b0;
        idx        = '0;
        pos        = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_reg) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PW'(pos);
            if (!found && cand[idx]) begin
                found           = 1'b1;
                grant_next[idx] = 1'b1;
                ptr_next        = (pos == N - 1) ? '0 : PW'(pos + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            grant_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
        end
    end

endmodule

// File: rtl/usr_reg_func_ctrl.sv
// Decodes a scanned function code into a one-hot FSEL or daisy-chain mode for the next
// data scan, and turns parallel-load requests into LOAD pulses that avoid JTAG updates.
module usr_reg_func_ctrl
    import usr_reg_ctrl_pkg::*;
#(
    parameter int            NREG       = 8,
    parameter int            FW         = 8,
    parameter logic [FW-1:0] CHAIN_CODE = FW'(DEF_CHAIN_CODE),
    parameter logic [FW-1:0] NOP_CODE   = FW'(DEF_NOP_CODE)
) (
    input logic                TCK,
    input logic                RST_N,
    usr_reg_func_ctrl_if.slave bus
);
    localparam int            CW       = cnt_width(FW);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    state_e          state_reg, state_next;
    logic [FW-1:0]   fcode_reg, fcode_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [NREG-1:0] fsel_reg, fsel_next;
    logic            chain_reg, chain_next;
    logic [FW-1:0]   active_reg, active_next;
    logic            bad_reg, bad_next;

    logic [NREG-1:0] dec_onehot;
    logic [NREG-1:0] arb_mask;
    logic [NREG-1:0] load_grant;
    logic            sel_update;
    logic            cnt_full;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            assign dec_onehot[gi] = (fcode_reg == FW'(gi + 1));
        end
    endgenerate

    assign sel_update = bus.SEL & bus.UPDATE;
    assign cnt_full   = (cnt_reg == CNT_FULL);

    always_comb begin
        state_next  = state_reg;
        fcode_next  = fcode_reg;
        cnt_next    = cnt_reg;
        fsel_next   = fsel_reg;
        chain_next  = chain_reg;
        active_next = active_reg;
        bad_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!bus.SEL) begin
                    cnt_next = '0;
                end else if (bus.UPDATE) begin
                    cnt_next = '0;
                    // NOP is tested first so a NOP_CODE inside 1..NREG still selects nothing.
                    if (cnt_full && fcode_reg == NOP_CODE) begin
                        state_next = IDLE;
                    end else if (cnt_full && |dec_onehot) begin
                        state_next  = ARMED;
                        fsel_next   = dec_onehot;
                        active_next = fcode_reg;
                    end else if (cnt_full && fcode_reg == CHAIN_CODE) begin
                        state_next  = ARMED;
                        chain_next  = 1'b1;
                        active_next = fcode_reg;
                    end else begin
                        bad_next = 1'b1;
                    end
                end else if (bus.SHIFT) begin
                    fcode_next = {bus.TDI, fcode_reg[FW-1:1]};
                    if (cnt_reg != CNT_SAT) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ARMED: begin
                if (!bus.SEL || bus.UPDATE) begin
                    state_next = IDLE;
                    fsel_next  = '0;
                    chain_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= IDLE;
            fcode_reg  <= '0;
            cnt_reg    <= '0;
            fsel_reg   <= '0;
            chain_reg  <= 1'b0;
            active_reg <= NOP_CODE;
            bad_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            fcode_reg  <= fcode_next;
            cnt_reg    <= cnt_next;
            fsel_reg   <= fsel_next;
            chain_reg  <= chain_next;
            active_reg <= active_next;
            bad_reg    <= bad_next;
        end
    end

    // A selected register or chain mode is being scanned; an update cycle blocks every grant.
    assign arb_mask = fsel_reg | {NREG{chain_reg}} | {NREG{sel_update}};

    rr_arbiter #(
        .N(NREG)
    ) u_load_arb (
        .clk  (TCK),
        .rst_n(RST_N),
        .req  (bus.LD_REQ),
        .mask (arb_mask),
        .grant(load_grant)
    );

    assign bus.FSEL        = fsel_reg;
    assign bus.DSY_CHAIN   = chain_reg;
    assign bus.ACTIVE_FUNC = active_reg;
    assign bus.BAD_CODE    = bad_reg;
    assign bus.BUSY        = (state_reg == ARMED);
    assign bus.LOAD        = load_grant;
    assign bus.TDO         = (state_reg == IDLE && bus.SEL) ? fcode_reg[0] : 1'b0;

endmodule

// File: tb/tb_usr_reg_func_ctrl.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs into a queue,
// a monitor pops and compares; directed checks cover the key scenarios.
module tb_usr_reg_func_ctrl;
    import usr_reg_ctrl_pkg::*;

    localparam int            NREG  = 8;
    localparam int            FW    = 8;
    localparam logic [FW-1:0] CHAIN = 8'hFF;
    localparam logic [FW-1:0] NOP   = 8'h00;

    logic TCK   = 1'b0;
    logic RST_N = 1'b1;

    usr_reg_func_ctrl_if #(.NREG(NREG), .FW(FW)) bus ();

    usr_reg_func_ctrl #(
        .NREG      (NREG),
        .FW        (FW),
        .CHAIN_CODE(CHAIN),
        .NOP_CODE  (NOP)
    ) dut (
        .TCK  (TCK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic [NREG-1:0] fsel;
        logic            chain;
        logic [NREG-1:0] load;
        logic [FW-1:0]   active;
        logic            bad;
        logic            busy;
        logic            tdo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit              m_armed  = 0;
    int              m_fsel   = -1;   // selected register index, -1 = none
    bit              m_chain  = 0;
    int              m_cnt    = 0;
    bit              m_hist[$];       // every TDI bit shifted into the code register since reset
    int              m_active = 0;
    int              m_ptr    = 0;
    bit              m_bad    = 0;
    logic [NREG-1:0] m_load   = '0;

    task automatic model_reset();
        m_armed  = 0;
        m_fsel   = -1;
        m_chain  = 0;
        m_cnt    = 0;
        m_hist.delete();
        m_active = int'(NOP);
        m_ptr    = 0;
        m_bad    = 0;
        m_load   = '0;
    endtask

    // Code register value = the last FW shifted bits, most recent at the MSB.
    function automatic int fcode_val();
        int v  = 0;
        int sz = m_hist.size();
        for (int j = 0; j < FW; j++) begin
            if (sz - FW + j >= 0 && m_hist[sz - FW + j]) v += (1 << j);
        end
        return v;
    endfunction

    function automatic exp_t model_outputs(input bit sel_now);
        exp_t e;
        e.fsel = '0;
        if (m_fsel >= 0) e.fsel[m_fsel] = 1'b1;
        e.chain  = m_chain;
        e.load   = m_load;
        e.active = FW'(m_active);
        e.bad    = m_bad;
        e.busy   = m_armed;
        e.tdo    = (!m_armed && sel_now) ? ((fcode_val() % 2) == 1) : 1'b0;
        return e;
    endfunction

    task automatic model_step();
        bit              s, sh, up, tdi;
        logic [NREG-1:0] req;
        int              g;
        int              code;
        s   = bus.SEL;
        sh  = bus.SHIFT;
        up  = bus.UPDATE;
        tdi = bus.TDI;
        req = bus.LD_REQ;
        g   = -1;
        if (!(s && up) && !m_chain) begin
            for (int k = 0; k < NREG; k++) begin
                int i = (m_ptr + k) % NREG;
                if (g < 0 && req[i] === 1'b1 && i != m_fsel) g = i;
            end
        end
        m_load = '0;
        if (g >= 0) begin
            m_load[g] = 1'b1;
            m_ptr     = (g + 1) % NREG;
        end
        m_bad = 0;
        if (!m_armed) begin
            if (!s) begin
                m_cnt = 0;
            end else if (up) begin
                code = fcode_val();
                if (m_cnt != FW) m_bad = 1;
                else if (code == int'(NOP)) m_bad = 0;
                else if (code >= 1 && code <= NREG) begin
                    m_armed = 1; m_fsel = code - 1; m_active = code;
                end else if (code == int'(CHAIN)) begin
                    m_armed = 1; m_chain = 1; m_active = code;
                end else m_bad = 1;
                m_cnt = 0;
            end else if (sh) begin
                m_hist.push_back(tdi);
                if (m_cnt < FW + 1) m_cnt++;
            end
        end else if (!s || up) begin
            m_armed = 0; m_fsel = -1; m_chain = 0;
        end
        exp_q.push_back(model_outputs(s));
    endtask

    always @(negedge RST_N) model_reset();

    always @(posedge TCK) begin
        if (!RST_N) begin
            model_reset();
            exp_q.push_back(model_outputs(bus.SEL));
        end else begin
            model_step();
        end
    end

    // ---------------- monitor ----------------
    always @(posedge TCK) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_fsel",   32'(bus.FSEL),        32'(e.fsel));
            chk("sb_chain",  32'(bus.DSY_CHAIN),   32'(e.chain));
            chk("sb_load",   32'(bus.LOAD),        32'(e.load));
            chk("sb_active", 32'(bus.ACTIVE_FUNC), 32'(e.active));
            chk("sb_bad",    32'(bus.BAD_CODE),    32'(e.bad));
            chk("sb_busy",   32'(bus.BUSY),        32'(e.busy));
            chk("sb_tdo",    32'(bus.TDO),         32'(e.tdo));
        end
    end

    // ---------------- load requesters ----------------
    bit              hold_mode = 1;
    logic [NREG-1:0] hold_val  = '0;

    always @(negedge TCK) begin
        if (hold_mode) begin
            bus.LD_REQ = hold_val;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (bus.LD_REQ[i] && bus.LOAD[i]) bus.LD_REQ[i] = 1'b0;
                else if (!bus.LD_REQ[i] && $urandom_range(0, 5) == 0) bus.LD_REQ[i] = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic code_scan(input logic [FW-1:0] code, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge TCK);
            bus.SEL = 1'b1; bus.SHIFT = 1'b1; bus.UPDATE = 1'b0;
            bus.TDI = code[i % FW];
        end
        @(negedge TCK);
        bus.SEL = 1'b1; bus.SHIFT = 1'b0; bus.UPDATE = 1'b1; bus.TDI = 1'b0;
        @(negedge TCK);
        bus.UPDATE = 1'b0;
    endtask

    task automatic data_scan(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge TCK);
            bus.SEL = 1'b1; bus.SHIFT = 1'b1; bus.TDI = 1'($urandom_range(0, 1));
        end
        @(negedge TCK);
        bus.SHIFT = 1'b0; bus.UPDATE = 1'b1;
        @(negedge TCK);
        bus.UPDATE = 1'b0;
    endtask

    task automatic rand_op();
        int            r;
        int            nb;
        logic [FW-1:0] code;
        r = int'($urandom_range(0, 9));
        if (r <= 4)      code = FW'($urandom_range(1, NREG));
        else if (r == 5) code = CHAIN;
        else if (r == 6) code = NOP;
        else if (r == 7) code = FW'($urandom_range(0, 255));
        else             code = FW'($urandom_range(NREG + 1, 254));
        nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(FW - 2, FW + 2)) : FW;
        code_scan(code, nb);
        if ($urandom_range(0, 4) == 0) begin
            @(negedge TCK);
            bus.SEL = 1'b0;
        end else begin
            data_scan(int'($urandom_range(0, 6)));
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge TCK);
            bus.SEL = 1'b0; bus.SHIFT = 1'b0;
        end
    endtask

    logic [NREG-1:0] arb_seq[4];

    initial begin
        arb_seq[0] = 8'h01; arb_seq[1] = 8'h02; arb_seq[2] = 8'h80; arb_seq[3] = 8'h01;
        bus.SEL = 1'b0; bus.SHIFT = 1'b0; bus.UPDATE = 1'b0; bus.TDI = 1'b0;
        model_reset();
        #2 RST_N = 1'b0;
        repeat (3) @(negedge TCK);
        RST_N = 1'b1;
        chk("rst_fsel",   32'(bus.FSEL), 32'h0);
        chk("rst_active", 32'(bus.ACTIVE_FUNC), 32'(NOP));
        chk("rst_busy",   32'(bus.BUSY), 32'h0);

        // Held requests rotate 0,1,7,0
        @(posedge TCK); #2;
        hold_val = 8'b1000_0011;
        for (int j = 0; j < 4; j++) begin
            @(posedge TCK); #1;
            chk("arb_seq", 32'(bus.LOAD), 32'(arb_seq[j]));
        end
        @(negedge TCK);
        bus.SEL = 1'b1; bus.UPDATE = 1'b1;
        @(posedge TCK); #1;
        chk("arb_upd_block", 32'(bus.LOAD), 32'h0);
        @(negedge TCK);
        bus.SEL = 1'b0; bus.UPDATE = 1'b0;
        #1 hold_val = '0;
        repeat (2) @(negedge TCK);

        // Code 3 select, masked request on register 2
        code_scan(8'h03, FW);
        chk("sel3_fsel", 32'(bus.FSEL), 32'h04);
        chk("sel3_busy", 32'(bus.BUSY), 32'h1);
        #1 hold_val = 8'b0000_0100;
        repeat (4) begin
            @(negedge TCK);
            bus.SHIFT = 1'b1; bus.TDI = 1'($urandom_range(0, 1));
            @(posedge TCK); #1;
            chk("mask_load", 32'(bus.LOAD[2]), 32'h0);
        end
        @(negedge TCK);
        bus.SHIFT = 1'b0; bus.UPDATE = 1'b1;
        #1 chk("hold_fsel", 32'(bus.FSEL), 32'h04);
        @(negedge TCK);
        bus.UPDATE = 1'b0;
        chk("rel_fsel",   32'(bus.FSEL), 32'h0);
        chk("rel_active", 32'(bus.ACTIVE_FUNC), 32'h3);
        chk("rel_busy",   32'(bus.BUSY), 32'h0);
        @(posedge TCK); #1;
        chk("unmask_load", 32'(bus.LOAD), 32'h04);
        hold_val = '0;
        repeat (2) @(negedge TCK);

        // Chain mode
        code_scan(CHAIN, FW);
        chk("chain_on",   32'(bus.DSY_CHAIN), 32'h1);
        chk("chain_fsel", 32'(bus.FSEL), 32'h0);
        data_scan(5);
        chk("chain_off",  32'(bus.DSY_CHAIN), 32'h0);
        chk("chain_busy", 32'(bus.BUSY), 32'h0);

        // Bad codes and NOP
        code_scan(8'h09, FW);
        chk("bad9_pulse", 32'(bus.BAD_CODE), 32'h1);
        chk("bad9_busy",  32'(bus.BUSY), 32'h0);
        @(negedge TCK);
        chk("bad9_end",   32'(bus.BAD_CODE), 32'h0);
        code_scan(8'h02, FW - 1);
        chk("short_pulse", 32'(bus.BAD_CODE), 32'h1);
        code_scan(8'h00, FW);
        chk("nop_nopulse", 32'(bus.BAD_CODE), 32'h0);
        chk("nop_busy",    32'(bus.BUSY), 32'h0);

        // Abort by dropping SEL, then a fresh scan
        code_scan(8'h05, FW);
        chk("abort_armed", 32'(bus.FSEL), 32'h10);
        @(negedge TCK);
        bus.SEL = 1'b0;
        @(negedge TCK);
        chk("abort_fsel",   32'(bus.FSEL), 32'h0);
        chk("abort_active", 32'(bus.ACTIVE_FUNC), 32'h5);
        code_scan(8'h01, FW);
        chk("after_abort", 32'(bus.FSEL), 32'h01);
        data_scan(2);

        // Randomized traffic
        #1 hold_mode = 0;
        repeat (150) rand_op();

        // Reset in the middle of a code scan
        @(negedge TCK);
        #1 hold_mode = 1; hold_val = '0;
        for (int i = 0; i < FW; i++) begin
            @(negedge TCK);
            bus.SEL = 1'b1; bus.SHIFT = 1'b1; bus.UPDATE = 1'b0; bus.TDI = 1'b1;
        end
        @(negedge TCK);
        RST_N = 1'b0;
        #1;
        chk("mrst_fsel",   32'(bus.FSEL), 32'h0);
        chk("mrst_chain",  32'(bus.DSY_CHAIN), 32'h0);
        chk("mrst_load",   32'(bus.LOAD), 32'h0);
        chk("mrst_active", 32'(bus.ACTIVE_FUNC), 32'(NOP));
        chk("mrst_bad",    32'(bus.BAD_CODE), 32'h0);
        chk("mrst_busy",   32'(bus.BUSY), 32'h0);
        chk("mrst_tdo",    32'(bus.TDO), 32'h0);
        bus.SEL = 1'b0; bus.SHIFT = 1'b0;
        repeat (2) @(negedge TCK);
        RST_N = 1'b1;
        code_scan(8'h02, FW);
        chk("post_rst_sel", 32'(bus.FSEL), 32'h02);
        data_scan(1);
        repeat (3) @(negedge TCK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usr_reg_func_ctrl.md
# usr_reg_func_ctrl

Function-select controller and parallel-load arbiter for a bank of JTAG user write registers sharing one USER data-register chain. A JTAG scan first shifts in a function code. The controller decodes it into a one-hot FSEL, or into daisy-chain mode, for the following data scan. Independently, it arbitrates internal parallel-load requests into single-cycle LOAD pulses that never collide with a JTAG update. It sits between the BSCAN primitive outputs and the user register bank.

## Interface
Parameters:
- NREG, 8, number of user registers controlled (1..2^FW-2)
- FW, 8, function-code width in bits
- CHAIN_CODE, 8'hFF, code selecting daisy-chain mode
- NOP_CODE, 8'h00, code that selects nothing

Ports:
- TCK  in  1  the single clock; all logic is on its rising edge
- RST_N  in  1  asynchronous active-low reset
- SEL  in  1  USER instruction active
- SHIFT  in  1  Shift-DR state, synchronous to TCK
- UPDATE  in  1  Update-DR state, synchronous to TCK
- TDI  in  1  serial data in
- LD_REQ  in  NREG  parallel-load request per register, level, held until acked
- FSEL  out  NREG  one-hot function select to the registers
- DSY_CHAIN  out  1  daisy-chain mode to all registers
- TDO  out  1  function-code shift-register LSB during the code scan, else 0
- LOAD  out  NREG  one-hot, one-cycle load pulse; also serves as the ack
- ACTIVE_FUNC  out  FW  last accepted code
- BAD_CODE  out  1  one-cycle pulse when a code scan is rejected
- BUSY  out  1  high in ARMED

## Operation
- Reset values: state IDLE, FSEL=0, DSY_CHAIN=0, TDO=0, LOAD=0, ACTIVE_FUNC=NOP_CODE, BAD_CODE=0, BUSY=0, fcode=0, bit count=0, round-robin pointer=0.
- States:
  - IDLE: code scan. On SEL&SHIFT: fcode <= {TDI, fcode[FW-1:1]} (right shift, LSB out first); bit counter increments, saturating at FW+1.
  - ARMED: selection held for the data scan.
- IDLE, on SEL&UPDATE, the code is decoded. A code is valid only if the count equals FW exactly.
  - Valid, 1 ≤ code ≤ NREG: go to ARMED; FSEL[code-1]=1; ACTIVE_FUNC=code.
  - Valid, code == CHAIN_CODE: go to ARMED; DSY_CHAIN=1; ACTIVE_FUNC=code.
  - Valid, code == NOP_CODE: stay in IDLE; no pulse.
  - Otherwise (invalid or out-of-range code, or wrong count): stay in IDLE; BAD_CODE pulses 1 cycle.
  - In all cases the counter clears.
- ARMED:
  - FSEL/DSY_CHAIN are held stable through the data scan's SHIFT and UPDATE cycles.
  - On SEL&UPDATE, return to IDLE; FSEL/DSY_CHAIN clear on the next edge.
  - If SEL=0 in any cycle, abort: go to IDLE and clear FSEL/DSY_CHAIN on the next edge. ACTIVE_FUNC is retained.
- IDLE with SEL=0: the counter clears.
- LOAD arbiter (round-robin):
  - Candidates are LD_REQ[i] with FSEL[i]=0 and DSY_CHAIN=0.
  - No grant in any cycle where SEL&UPDATE=1.
  - At most one grant per cycle. The search starts at the pointer; after a grant to i, pointer = (i+1) mod NREG.
  - A request still high after its grant is eligible again only after every other pending request has been granted.
- Simultaneous events:
  - UPDATE and LD_REQ in the same cycle: UPDATE wins; the grant is deferred ≥1 cycle.
  - Async reset mid-scan: all state returns to reset values immediately; a partial code is discarded.

## Timing
- Decode latency: FSEL is valid on the edge after the UPDATE cycle, and therefore through the whole next scan.
- Release: FSEL drops 1 cycle after the data-scan UPDATE. The register samples UPDATE while FSEL is still high.
- LOAD: registered, asserted 1 cycle after an eligible LD_REQ is sampled, width exactly 1 cycle.
- TDO: combinational from fcode[0], gated by (state==IDLE & SEL).
- BAD_CODE: registered, 1 cycle after the UPDATE.

## Structure
- Package usr_reg_ctrl_pkg holds the state enum (IDLE, ARMED) and the default CHAIN_CODE/NOP_CODE constants.
- One sub-module, rr_arbiter (parameter N; inputs req, mask; outputs one-hot grant; internal pointer), instanced once for LOAD.
- Code shift register, counter and FSM live in the top module.

## Test plan
- Code select: shift 8'h03 (8 bits), UPDATE -> FSEL=8'b0000_0100 from the next edge. Data scan plus UPDATE -> FSEL=0 one cycle after; ACTIVE_FUNC=3.
- Chain mode: shift 8'hFF, UPDATE -> DSY_CHAIN=1, FSEL=0. After the data UPDATE -> DSY_CHAIN=0, BUSY=0.
- Bad code:
  - 8'h09 with NREG=8 -> BAD_CODE 1-cycle pulse, state IDLE.
  - 7-bit scan of 8'h02 -> BAD_CODE pulse.
  - 8'h00 -> no pulse.
- Abort: in ARMED (code 5), drop SEL for 1 cycle -> FSEL=0 next edge. A new code scan is accepted.
- Arbitration: LD_REQ=8'b1000_0011 held -> LOAD sequence bit0, bit1, bit7, bit0, each 1 cycle. A cycle with SEL&UPDATE produces LOAD=0.
- Masking and reset: LD_REQ[2]=1 while FSEL[2]=1 -> no LOAD[2] until FSEL clears. RST_N low mid-shift -> all outputs at reset values the same cycle.
